circle_lines_stream: RTL and testbench

- Parametrised successor to the generated midpoint-circle point generator.
- Emits the 8-way symmetric perimeter points of a circle centred at (s_x, s_y) with radius `height`, one point per output handshake.
- Adds a ready/valid backpressure handshake, a per-octant enable mask, an asynchronous reset and a configurable coordinate width.
- Sits between a geometry command source and a pixel/line consumer (e.g. a framebuffer writer).

---
 rtl/circle_pkg.sv | 62 ++++++
 rtl/circle_point_sel.sv | 48 ++++
 rtl/circle_lines_stream.sv | 193 +++++++++++++++++++
 tb/tb_circle_lines_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and helpers for the circle_lines_stream point generator.
// Holds the FSM state enum, point-index constants and offset selection.
package circle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        EMIT,
        STEP,
        FIN
    } state_t;

    localparam logic [2:0] PT_0 = 3'd0;
    localparam logic [2:0] PT_1 = 3'd1;
    localparam logic [2:0] PT_2 = 3'd2;
    localparam logic [2:0] PT_3 = 3'd3;
    localparam logic [2:0] PT_4 = 3'd4;
    localparam logic [2:0] PT_5 = 3'd5;
    localparam logic [2:0] PT_6 = 3'd6;
    localparam logic [2:0] PT_7 = 3'd7;

    // {sign_a, swap, sign_b}: out0 = c +/- (swap ? y : x),
    // out1 = c +/- (swap ? x : y)
    function automatic logic [2:0] pt_sel(input logic [2:0] k);
        logic [2:0] s;
        s = 3'b000;
        unique case (k)
            PT_0: s = 3'b000;
            PT_1: s = 3'b001;
            PT_2: s = 3'b100;
            PT_3: s = 3'b101;
            PT_4: s = 3'b010;
            PT_5: s = 3'b011;
            PT_6: s = 3'b110;
            PT_7: s = 3'b111;
        endcase
        return s;
    endfunction

    // v selects the coordinate (0: x, 1: y), s its sign
    function automatic logic comp_eq(
        input logic s1, v1, s2, v2,
        input logic x0, y0, xy
    );
        if (v1 == v2)
            return (s1 == s2) || (v1 ? y0 : x0);
        return (s1 == s2) ? xy : (x0 && y0);
    endfunction

    function automatic logic pt_eq(
        input logic [2:0] k, j,
        input logic x0, y0, xy
    );
        logic [2:0] a;
        logic [2:0] b;
        a = pt_sel(k);
        b = pt_sel(j);
        return comp_eq(a[2], a[1], b[2], b[1], x0, y0, xy)
            && comp_eq(a[0], !a[1], b[0], !b[1], x0, y0, xy);
    endfunction

endpackage

// File: rtl/circle_point_sel.sv
// Next-enabled point finder: lowest enabled index >= cur, plus last flag.
// In: cur, mask, x_zero/y_zero/x_eq_y. Out: nidx, last, found.
// CIRCLE_LINES_DEDUP_EN also drops indices repeating a lower point.
module circle_point_sel
    import circle_pkg::*;
(
    input  logic [2:0] cur,
    input  logic [7:0] mask,
    input  logic       x_zero,
    input  logic       y_zero,
    input  logic       x_eq_y,
    output logic [2:0] nidx,
    output logic       last,
    output logic       found
);

    logic [7:0] en;

`ifdef CIRCLE_LINES_DEDUP_EN
    always_comb begin
        en = mask;
        for (int k = 1; k < 8; k++)
            for (int j = 0; j < k; j++)
                if (mask[j] && pt_eq(3'(k), 3'(j),
                                     x_zero, y_zero, x_eq_y))
                    en[k] = 1'b0;
    end
`else
    logic unused_dedup;
    assign unused_dedup = ^{x_zero, y_zero, x_eq_y};
    assign en = mask;
`endif

    always_comb begin
        nidx  = PT_0;
        found = 1'b0;
        last  = 1'b1;
        for (int k = 7; k >= 0; k--)
            if (en[k] && k >= int'(cur)) begin
                nidx  = 3'(k);
                found = 1'b1;
            end
        for (int k = 0; k < 8; k++)
            if (en[k] && k > int'(nidx))
                last = 1'b0;
    end

endmodule

// File: rtl/circle_lines_stream.sv
// Midpoint-circle perimeter streamer, one point per ready/valid transfer.
// In: _clock, _reset_n, _start, s_x, s_y, height, octant_mask, _ready.
// Out: _out0/_out1 point, _valid, _done, _busy. Macro: CIRCLE_LINES_DEDUP_EN.
module circle_lines_stream
    import circle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DW    = WIDTH + 4
) (
    input  logic             _clock,
    input  logic             _reset_n,
    input  logic             _start,
    input  logic [WIDTH-1:0] s_x,
    input  logic [WIDTH-1:0] s_y,
    input  logic [WIDTH-1:0] height,
    input  logic [7:0]       octant_mask,
    input  logic             _ready,
    output logic [WIDTH-1:0] _out0,
    output logic [WIDTH-1:0] _out1,
    output logic             _valid,
    output logic             _done,
    output logic             _busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d;
    logic signed [DW-1:0] d_q, d_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] mask_q, mask_d;
    logic last_q, last_d, valid_q, valid_d;
    logic done_q, done_d, busy_q, busy_d;

    logic [WIDTH-1:0] nx, ny, ux, uy, a_off, b_off, pt0, pt1;
    logic signed [DW-1:0] nxe, nye, he, nd, d_init;
    logic [2:0] from, nidx, ps;
    logic d_pos, more, found, sel_last, load, fin;

    // Step candidates, computed from the current (pre-step) values
    assign d_pos  = !d_q[DW-1] && (d_q != '0);
    assign nx     = x_q + ONE;
    assign ny     = d_pos ? y_q - ONE : y_q;
    assign nxe    = DW'(nx);
    assign nye    = DW'(ny);
    assign he     = DW'(height);
    assign d_init = DW'(3) - (he <<< 1);
    assign nd     = d_pos ? d_q + ((nxe - nye) <<< 2) + DW'(10)
                          : d_q + (nxe <<< 2) + DW'(6);

    // x,y never go negative here, so the unsigned compare equals the
    // signed one; a zero radius stays a single group.
    assign more = (y_q >= x_q) && (y_q != '0);

    // STEP loads the first point of the next group from the new x,y
    assign ux   = (state_q == STEP) ? nx : x_q;
    assign uy   = (state_q == STEP) ? ny : y_q;
    assign from = (state_q == EMIT) ? idx_q + 3'd1 : PT_0;

    circle_point_sel u_sel (
        .cur    (from),
        .mask   (mask_q),
        .x_zero (ux == '0),
        .y_zero (uy == '0),
        .x_eq_y (ux == uy),
        .nidx   (nidx),
        .last   (sel_last),
        .found  (found)
    );

    assign ps    = pt_sel(nidx);
    assign a_off = ps[1] ? uy : ux;
    assign b_off = ps[1] ? ux : uy;
    assign pt0   = cx_q + (ps[2] ? -a_off : a_off);
    assign pt1   = cy_q + (ps[0] ? -b_off : b_off);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        d_d     = d_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        mask_d  = mask_q;
        out0_d  = out0_q;
        out1_d  = out1_q;
        valid_d = valid_q;
        done_d  = done_q;
        busy_d  = busy_q;
        load    = 1'b0;
        fin     = 1'b0;
        unique case (state_q)
            IDLE: ;
            CAPTURE: begin
                load = found;
                fin  = !found;
            end
            EMIT: begin
                if (valid_q && _ready) begin
                    valid_d = 1'b0;
                    if (!last_q)
                        load = 1'b1;
                    else if (more)
                        state_d = STEP;
                    else
                        fin = 1'b1;
                end
            end
            STEP: begin
                x_d  = nx;
                y_d  = ny;
                d_d  = nd;
                load = found;
                fin  = !found;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            out0_d  = pt0;
            out1_d  = pt1;
            valid_d = 1'b1;
            idx_d   = nidx;
            last_d  = sel_last;
            state_d = EMIT;
        end
        if (fin) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
        // Start wins over everything, including a same-cycle transfer
        if (_start) begin
            state_d = CAPTURE;
            cx_d    = s_x;
            cy_d    = s_y;
            mask_d  = octant_mask;
            x_d     = '0;
            y_d     = height;
            d_d     = d_init;
            idx_d   = PT_0;
            last_d  = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge _clock or negedge _reset_n) begin
        if (!_reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            idx_q   <= PT_0;
            last_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            mask_q  <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            d_q     <= d_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            mask_q  <= mask_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign _out0  = out0_q;
    assign _out1  = out1_q;
    assign _valid = valid_q;
    assign _done  = done_q;
    assign _busy  = busy_q;

endmodule

// File: tb/tb_circle_lines_stream.sv
// Directed bench for circle_lines_stream; expected points come from
// hand-derived (x,y) group lists expanded through the 8-way offset table.
module tb_circle_lines_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] sx, sy, r;
    logic [7:0]  mask;
    logic        ready;
    logic [31:0] out0, out1;
    logic        valid, done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] grp[$];
    logic [63:0] exp_q[$];
    logic [63:0] got[$];

    always #5 clk = ~clk;

    circle_lines_stream dut (
        ._clock      (clk),
        ._reset_n    (rst_n),
        ._start      (start),
        .s_x         (sx),
        .s_y         (sy),
        .height      (r),
        .octant_mask (mask),
        ._ready      (ready),
        ._out0       (out0),
        ._out1       (out1),
        ._valid      (valid),
        ._done       (done),
        ._busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pt(input logic [31:0] cx, cy, x, y,
                                       input int k);
        logic [31:0] a, b;
        case (k)
            0: begin a = x;  b = y;  end
            1: begin a = x;  b = -y; end
            2: begin a = -x; b = y;  end
            3: begin a = -x; b = -y; end
            4: begin a = y;  b = x;  end
            5: begin a = y;  b = -x; end
            6: begin a = -y; b = x;  end
            default: begin a = -y; b = -x; end
        endcase
        return {cx + a, cy + b};
    endfunction

    task automatic build(input logic [31:0] cx, cy, input logic [7:0] m);
        exp_q.delete();
        foreach (grp[g]) begin
`ifdef CIRCLE_LINES_DEDUP_EN
            int base = exp_q.size();
`endif
            for (int k = 0; k < 8; k++) begin
                logic [63:0] p;
                bit dup;
                p = pt(cx, cy, grp[g][63:32], grp[g][31:0], k);
                dup = 1'b0;
`ifdef CIRCLE_LINES_DEDUP_EN
                for (int i = base; i < exp_q.size(); i++)
                    if (exp_q[i] == p) dup = 1'b1;
`endif
                if (m[k] && !dup) exp_q.push_back(p);
            end
        end
    endtask

    task automatic start_run(input logic [31:0] x, y, rad,
                             input logic [7:0] m);
        sx = x; sy = y; r = rad; mask = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic collect(input bit rnd, input int budget,
                           input int exp_first);
        int cyc = 0;
        int first = -1;
        bit held_v = 1'b0;
        logic [63:0] held = '0;
        got.delete();
        while (!done && cyc < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held_v) begin
                check("hold_v", 64'(valid), 64'd1);
                check("hold_pt", {out0, out1}, held);
            end
            if (valid && first < 0) first = cyc;
            if (valid && ready) got.push_back({out0, out1});
            held_v = valid && !ready;
            held = {out0, out1};
            @(posedge clk); #1;
            cyc++;
        end
        ready = 1'b1;
        check("done_in_budget", 64'(done), 64'd1);
        check("latency", 64'(first), 64'(exp_first));
    endtask

    task automatic compare(input string tag);
        check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        int xf;
        int cyc;
        rst_n = 1'b1; start = 1'b0; ready = 1'b1;
        sx = '0; sy = '0; r = '0; mask = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out", {out0, out1}, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // r=0: one group, all points at the centre
        grp = '{64'h00000000_00000000};
        build(32'd10, 32'd20, 8'hFF);
        start_run(32'd10, 32'd20, 32'd0, 8'hFF);
        check("r0_capture_valid", 64'(valid), 64'd0);
        check("r0_capture_busy", 64'(busy), 64'd1);
        collect(1'b0, 100, 1);
        compare("r0");
        check("r0_busy_end", 64'(busy), 64'd0);

        // r=1 around the origin, exercising wrap to negative
        grp = '{64'h00000000_00000001, 64'h00000001_00000000};
        build(32'd0, 32'd0, 8'hFF);
        start_run(32'd0, 32'd0, 32'd1, 8'hFF);
        check("r1_done_clr", 64'(done), 64'd0);
        collect(1'b0, 100, 1);
        compare("r1");

        // r=2: groups (0,2) (1,2) (2,1)
        grp = '{64'h00000000_00000002, 64'h00000001_00000002,
                64'h00000002_00000001};
        build(32'd100, 32'd100, 8'hFF);
        start_run(32'd100, 32'd100, 32'd2, 8'hFF);
        collect(1'b0, 100, 1);
        compare("r2");

        // r=5, index 0 only, random backpressure
        grp = '{64'h00000000_00000005, 64'h00000001_00000005,
                64'h00000002_00000004, 64'h00000003_00000003,
                64'h00000004_00000002};
        build(32'd100, 32'd200, 8'h01);
        start_run(32'd100, 32'd200, 32'd5, 8'h01);
        collect(1'b1, 300, 1);
        compare("r5");

        // empty mask goes straight to done
        grp = '{64'h00000000_00000004};
        build(32'd7, 32'd7, 8'h00);
        start_run(32'd7, 32'd7, 32'd4, 8'h00);
        collect(1'b0, 20, -1);
        compare("m0");

        // restart after 5 transfers of an r=2 run
        grp = '{64'h00000000_00000002, 64'h00000001_00000002,
                64'h00000002_00000001};
        build(32'd0, 32'd0, 8'hFF);
        start_run(32'd0, 32'd0, 32'd2, 8'hFF);
        xf = 0;
        cyc = 0;
        got.delete();
        while (xf < 5 && cyc < 50) begin
            if (valid && ready) begin
                got.push_back({out0, out1});
                xf++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("abort_xfers", 64'(xf), 64'd5);
        for (int i = 0; i < got.size(); i++)
            check($sformatf("abort_pre_%0d", i), got[i], exp_q[i]);
        check("abort_pending", 64'(valid), 64'd1);
        start_run(32'd50, 32'd60, 32'd3, 8'hFF);
        check("abort_drop", 64'(valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("abort_first_v", 64'(valid), 64'd1);
        check("abort_first_pt", {out0, out1}, {32'd50, 32'd63});
        grp = '{64'h00000000_00000003, 64'h00000001_00000003,
                64'h00000002_00000002, 64'h00000003_00000001};
        build(32'd50, 32'd60, 8'hFF);
        collect(1'b0, 100, 0);
        compare("r3");

        // async reset while a point is held
        ready = 1'b0;
        start_run(32'd0, 32'd0, 32'd5, 8'hFF);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_valid", 64'(valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_out", {out0, out1}, 64'd0);
        #2 rst_n = 1'b1;
        ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("idle_valid", 64'(valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
